// File: rtl/fwd_hazard_unit_if.sv
// Bundle of pipeline-side signals exchanged with the forwarding/hazard unit.
// The pipeline uses the master view and the hazard unit uses the slave view.
interface fwd_hazard_unit_if #(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2
);
  logic                      id_valid;
  logic [NUM_SRC*REG_AW-1:0] id_src;
  logic [NUM_SRC*REG_AW-1:0] ex_src;
  logic                      ex_memread;
  logic [REG_AW-1:0]         ex_rd;
  logic                      mem_regwrite;
  logic                      mem_memread;
  logic [REG_AW-1:0]         mem_rd;
  logic                      wb_regwrite;
  logic [REG_AW-1:0]         wb_rd;
  logic                      pipe_flush;
  logic                      perf_clr;
  logic [2*NUM_SRC-1:0]      forward_sel;
  logic                      pc_write;
  logic                      ifid_write;
  logic                      idex_bubble;
  logic                      stalling;
  logic [15:0]               stall_count;

  modport master (
    output id_valid, id_src, ex_src, ex_memread, ex_rd,
           mem_regwrite, mem_memread, mem_rd, wb_regwrite, wb_rd,
           pipe_flush, perf_clr,
    input  forward_sel, pc_write, ifid_write, idex_bubble, stalling, stall_count
  );

  modport slave (
    input  id_valid, id_src, ex_src, ex_memread, ex_rd,
           mem_regwrite, mem_memread, mem_rd, wb_regwrite, wb_rd,
           pipe_flush, perf_clr,
    output forward_sel, pc_write, ifid_write, idex_bubble, stalling, stall_count
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding selects for EX plus a counter-based load-use stall FSM
// driving the PC / IF/ID enables and the ID/EX bubble.
module fwd_hazard_unit #(
  parameter int REG_AW    = 5,
  parameter int NUM_SRC   = 2,
  parameter int LOAD_LAT  = 1,
  parameter int WB_BYPASS = 1
) (
  input logic             clk,
  input logic             rst_n,
  fwd_hazard_unit_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_e;

  localparam logic              BYPASS_EN = (WB_BYPASS != 32'sd0);
  localparam logic              LAT_MULTI = (LOAD_LAT > 32'sd1);
  localparam logic [3:0]        LAT_M1    = 4'(LOAD_LAT - 32'sd1);
  localparam logic [REG_AW-1:0] RD_ZERO   = {REG_AW{1'b0}};

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 pwb_valid_q;
  logic [REG_AW-1:0]    pwb_rd_q;
  logic [15:0]          stall_count_q, stall_count_d;
  logic                 hz_s;
  logic                 stall_now_s;
  logic [2*NUM_SRC-1:0] fwd_sel_s;

  // Per-operand forward source, EX/MEM over MEM/WB over post-writeback latch.
  always_comb begin
    fwd_sel_s = {(2*NUM_SRC){1'b0}};
    for (int i = 0; i < NUM_SRC; i++) begin
      if (bus.mem_regwrite && !bus.mem_memread && (bus.mem_rd != RD_ZERO) &&
          (bus.mem_rd == bus.ex_src[i*REG_AW +: REG_AW])) begin
        fwd_sel_s[2*i +: 2] = 2'b10;
      end else if (bus.wb_regwrite && (bus.wb_rd != RD_ZERO) &&
                   (bus.wb_rd == bus.ex_src[i*REG_AW +: REG_AW])) begin
        fwd_sel_s[2*i +: 2] = 2'b01;
      end else if (BYPASS_EN && pwb_valid_q && (pwb_rd_q != RD_ZERO) &&
                   (pwb_rd_q == bus.ex_src[i*REG_AW +: REG_AW])) begin
        fwd_sel_s[2*i +: 2] = 2'b11;
      end else begin
        fwd_sel_s[2*i +: 2] = 2'b00;
      end
    end
  end

  // Load in EX whose destination is read by the instruction in ID.
  always_comb begin
    hz_s = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      hz_s = hz_s | (bus.id_valid && bus.ex_memread && (bus.ex_rd != RD_ZERO) &&
                     (bus.ex_rd == bus.id_src[i*REG_AW +: REG_AW]));
    end
  end

  // Stall FSM: detection cycle stalls from IDLE, STALL covers the remaining cycles.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall_now_s = 1'b0;
    case (state_q)
      IDLE: begin
        stall_now_s = hz_s && !bus.pipe_flush;
        if (stall_now_s && LAT_MULTI) begin
          state_d = STALL;
          cnt_d   = LAT_M1;
        end else begin
          state_d = IDLE;
          cnt_d   = cnt_q;
        end
      end
      STALL: begin
        stall_now_s = !bus.pipe_flush;
        if (bus.pipe_flush || (cnt_q <= 4'd1)) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          state_d = STALL;
          cnt_d   = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d     = IDLE;
        cnt_d       = 4'd0;
        stall_now_s = 1'b0;
      end
    endcase
  end

  // Saturating stall-cycle counter; a clear request beats an increment.
  always_comb begin
    if (bus.perf_clr) begin
      stall_count_d = 16'd0;
    end else if (stall_now_s && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end else begin
      stall_count_d = stall_count_q;
    end
  end

  // State, counters and the post-writeback latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= 4'd0;
      pwb_valid_q   <= 1'b0;
      pwb_rd_q      <= RD_ZERO;
      stall_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pwb_valid_q   <= bus.wb_regwrite;
      pwb_rd_q      <= bus.wb_rd;
      stall_count_q <= stall_count_d;
    end
  end

  assign bus.forward_sel = fwd_sel_s;
  assign bus.pc_write    = !stall_now_s;
  assign bus.ifid_write  = !stall_now_s;
  assign bus.idex_bubble = stall_now_s || bus.pipe_flush;
  assign bus.stalling    = (state_q == STALL);
  assign bus.stall_count = stall_count_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench: three instances (LOAD_LAT 1/3/4, bypass on/off/on) share one
// stimulus; forwarding is table driven, stall corner cases are hand sequences.
module tb_fwd_hazard_unit;
  localparam int AW = 5;
  localparam int NS = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          id_valid, ex_memread, mem_regwrite, mem_memread;
  logic          wb_regwrite, pipe_flush, perf_clr;
  logic [NS*AW-1:0] id_src, ex_src;
  logic [AW-1:0] ex_rd, mem_rd, wb_rd;

  fwd_hazard_unit_if #(.REG_AW(AW), .NUM_SRC(NS)) bus [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_drv
    assign bus[g].id_valid     = id_valid;
    assign bus[g].id_src       = id_src;
    assign bus[g].ex_src       = ex_src;
    assign bus[g].ex_memread   = ex_memread;
    assign bus[g].ex_rd        = ex_rd;
    assign bus[g].mem_regwrite = mem_regwrite;
    assign bus[g].mem_memread  = mem_memread;
    assign bus[g].mem_rd       = mem_rd;
    assign bus[g].wb_regwrite  = wb_regwrite;
    assign bus[g].wb_rd        = wb_rd;
    assign bus[g].pipe_flush   = pipe_flush;
    assign bus[g].perf_clr     = perf_clr;
  end

  fwd_hazard_unit #(.REG_AW(AW), .NUM_SRC(NS), .LOAD_LAT(1), .WB_BYPASS(1))
    u_lat1 (.clk(clk), .rst_n(rst_n), .bus(bus[0]));
  fwd_hazard_unit #(.REG_AW(AW), .NUM_SRC(NS), .LOAD_LAT(3), .WB_BYPASS(0))
    u_lat3 (.clk(clk), .rst_n(rst_n), .bus(bus[1]));
  fwd_hazard_unit #(.REG_AW(AW), .NUM_SRC(NS), .LOAD_LAT(4), .WB_BYPASS(1))
    u_lat4 (.clk(clk), .rst_n(rst_n), .bus(bus[2]));

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       mrw;
    logic       mmr;
    logic [4:0] mrd;
    logic       wrw;
    logic [4:0] wrd;
    logic [9:0] exs;
    logic [3:0] e_byp;
    logic [3:0] e_nobyp;
  } fvec_t;

  fvec_t vecs[11];
  logic [4:0] pw_l1, pw_l3, pw_l4, st_l3, st_l4;

  initial begin
    // ex_src packing {operand1, operand0}; rows depend on the previous row's wb.
    vecs[0]  = '{1'b0, 1'b0, 5'd0, 1'b0, 5'd0, {5'd0, 5'd0}, 4'b0000, 4'b0000};
    vecs[1]  = '{1'b1, 1'b0, 5'd8, 1'b1, 5'd8, {5'd8, 5'd8}, 4'b1010, 4'b1010};
    vecs[2]  = '{1'b1, 1'b0, 5'd0, 1'b1, 5'd8, {5'd8, 5'd8}, 4'b0101, 4'b0101};
    vecs[3]  = '{1'b1, 1'b1, 5'd8, 1'b0, 5'd0, {5'd8, 5'd3}, 4'b1100, 4'b0000};
    vecs[4]  = '{1'b1, 1'b0, 5'd3, 1'b1, 5'd7, {5'd7, 5'd3}, 4'b0110, 4'b0110};
    vecs[5]  = '{1'b0, 1'b0, 5'd0, 1'b0, 5'd0, {5'd7, 5'd7}, 4'b1111, 4'b0000};
    vecs[6]  = '{1'b0, 1'b0, 5'd0, 1'b1, 5'd9, {5'd0, 5'd0}, 4'b0000, 4'b0000};
    vecs[7]  = '{1'b0, 1'b0, 5'd0, 1'b0, 5'd0, {5'd0, 5'd9}, 4'b0011, 4'b0000};
    vecs[8]  = '{1'b1, 1'b0, 5'd0, 1'b1, 5'd0, {5'd0, 5'd0}, 4'b0000, 4'b0000};
    vecs[9]  = '{1'b0, 1'b0, 5'd0, 1'b0, 5'd0, {5'd0, 5'd0}, 4'b0000, 4'b0000};
    vecs[10] = '{1'b0, 1'b0, 5'd4, 1'b1, 5'd4, {5'd4, 5'd4}, 4'b0101, 4'b0101};

    // Bit c is the expected value in stall-sequence cycle c.
    pw_l1 = 5'b11110;
    pw_l3 = 5'b11000;
    pw_l4 = 5'b10000;
    st_l3 = 5'b00110;
    st_l4 = 5'b01110;

    id_valid = 1'b0; ex_memread = 1'b0; mem_regwrite = 1'b0; mem_memread = 1'b0;
    wb_regwrite = 1'b0; pipe_flush = 1'b0; perf_clr = 1'b0;
    id_src = '0; ex_src = '0; ex_rd = '0; mem_rd = '0; wb_rd = '0;

    #3;
    chk("rst_fwd",    32'(bus[0].forward_sel), 32'h0);
    chk("rst_pc",     32'(bus[0].pc_write),    32'h1);
    chk("rst_ifid",   32'(bus[0].ifid_write),  32'h1);
    chk("rst_bubble", 32'(bus[0].idex_bubble), 32'h0);
    chk("rst_stall",  32'(bus[2].stalling),    32'h0);
    chk("rst_cnt",    32'(bus[1].stall_count), 32'h0);
    #5 rst_n = 1'b1;
    tick();

    for (int v = 0; v < 11; v++) begin
      mem_regwrite = vecs[v].mrw; mem_memread = vecs[v].mmr; mem_rd = vecs[v].mrd;
      wb_regwrite  = vecs[v].wrw; wb_rd = vecs[v].wrd; ex_src = vecs[v].exs;
      #2;
      chk($sformatf("fwd_byp_v%0d", v),   32'(bus[0].forward_sel), 32'(vecs[v].e_byp));
      chk($sformatf("fwd_nobyp_v%0d", v), 32'(bus[1].forward_sel), 32'(vecs[v].e_nobyp));
      chk($sformatf("fwd_lat4_v%0d", v),  32'(bus[2].forward_sel), 32'(vecs[v].e_byp));
      tick();
    end
    mem_regwrite = 1'b0; wb_regwrite = 1'b0; mem_rd = '0; wb_rd = '0; ex_src = '0;

    // Load-use: hazard present only in the detection cycle.
    ex_memread = 1'b1; ex_rd = 5'd5; id_src = {5'd5, 5'd0};
    for (int c = 0; c < 5; c++) begin
      id_valid = (c == 0);
      #2;
      chk($sformatf("lu_pc_l1_c%0d", c),   32'(bus[0].pc_write),    32'(pw_l1[c]));
      chk($sformatf("lu_bub_l1_c%0d", c),  32'(bus[0].idex_bubble), 32'(!pw_l1[c]));
      chk($sformatf("lu_st_l1_c%0d", c),   32'(bus[0].stalling),    32'h0);
      chk($sformatf("lu_pc_l3_c%0d", c),   32'(bus[1].pc_write),    32'(pw_l3[c]));
      chk($sformatf("lu_ifid_l3_c%0d", c), 32'(bus[1].ifid_write),  32'(pw_l3[c]));
      chk($sformatf("lu_st_l3_c%0d", c),   32'(bus[1].stalling),    32'(st_l3[c]));
      chk($sformatf("lu_pc_l4_c%0d", c),   32'(bus[2].pc_write),    32'(pw_l4[c]));
      chk($sformatf("lu_st_l4_c%0d", c),   32'(bus[2].stalling),    32'(st_l4[c]));
      tick();
    end
    chk("lu_cnt_l1", 32'(bus[0].stall_count), 32'd1);
    chk("lu_cnt_l3", 32'(bus[1].stall_count), 32'd3);
    chk("lu_cnt_l4", 32'(bus[2].stall_count), 32'd4);

    // Destination r0 and non-load producers never stall.
    ex_rd = 5'd0; id_src = {5'd0, 5'd0}; id_valid = 1'b1;
    #2;
    chk("rd0_pc",     32'(bus[1].pc_write),    32'h1);
    chk("rd0_bubble", 32'(bus[1].idex_bubble), 32'h0);
    tick();
    ex_rd = 5'd5; id_src = {5'd0, 5'd5}; ex_memread = 1'b0;
    #2;
    chk("noload_pc", 32'(bus[1].pc_write), 32'h1);
    tick();
    ex_memread = 1'b1; id_valid = 1'b0;

    // Flush coincident with the hazard.
    id_valid = 1'b1; pipe_flush = 1'b1;
    #2;
    chk("flhz_pc",     32'(bus[2].pc_write),    32'h1);
    chk("flhz_bubble", 32'(bus[2].idex_bubble), 32'h1);
    chk("flhz_st",     32'(bus[2].stalling),    32'h0);
    tick();
    id_valid = 1'b0; pipe_flush = 1'b0;
    #2;
    chk("flhz_cnt", 32'(bus[2].stall_count), 32'd4);
    chk("flhz_st2", 32'(bus[2].stalling),    32'h0);
    tick();

    // Flush in the second stall cycle of the LOAD_LAT=4 instance.
    id_valid = 1'b1;
    #2;
    chk("flmid_pc1", 32'(bus[2].pc_write), 32'h0);
    tick();
    id_valid = 1'b0; pipe_flush = 1'b1;
    #2;
    chk("flmid_pc2",     32'(bus[2].pc_write),    32'h1);
    chk("flmid_bubble2", 32'(bus[2].idex_bubble), 32'h1);
    chk("flmid_st2",     32'(bus[2].stalling),    32'h1);
    tick();
    pipe_flush = 1'b0;
    #2;
    chk("flmid_st3",  32'(bus[2].stalling),    32'h0);
    chk("flmid_pc3",  32'(bus[2].pc_write),    32'h1);
    chk("flmid_cnt3", 32'(bus[2].stall_count), 32'd5);
    tick();

    // Asynchronous reset in the middle of a stall, with the post-WB latch loaded.
    id_valid = 1'b1; wb_regwrite = 1'b1; wb_rd = 5'd9;
    tick();
    id_valid = 1'b0; wb_regwrite = 1'b0; wb_rd = 5'd0; ex_src = {5'd0, 5'd9};
    #2;
    chk("pre_rst_st",  32'(bus[2].stalling),    32'h1);
    chk("pre_rst_pc",  32'(bus[2].pc_write),    32'h0);
    chk("pre_rst_fwd", 32'(bus[0].forward_sel), 32'h3);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_st",     32'(bus[2].stalling),    32'h0);
    chk("mid_rst_pc",     32'(bus[2].pc_write),    32'h1);
    chk("mid_rst_bubble", 32'(bus[2].idex_bubble), 32'h0);
    chk("mid_rst_cnt",    32'(bus[2].stall_count), 32'h0);
    chk("mid_rst_fwd",    32'(bus[0].forward_sel), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    ex_src = '0;
    tick();

    // Continuous load-use to saturate the counter, then clear while stalling.
    ex_rd = 5'd5; id_src = {5'd5, 5'd0}; id_valid = 1'b1;
    repeat (65540) tick();
    chk("sat_l1", 32'(bus[0].stall_count), 32'hFFFF);
    chk("sat_l4", 32'(bus[2].stall_count), 32'hFFFF);
    perf_clr = 1'b1;
    tick();
    chk("clr_l1", 32'(bus[0].stall_count), 32'h0);
    chk("clr_l3", 32'(bus[1].stall_count), 32'h0);
    perf_clr = 1'b0;
    tick();
    chk("post_clr_l1", 32'(bus[0].stall_count), 32'd1);
    chk("post_clr_l3", 32'(bus[1].stall_count), 32'd1);
    id_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
